// File: rtl/bcd_to_binary_pkg.sv
// Shared display-path definitions: converter state encoding, blank digit code
// and default sizing for the BCD/binary converters.
package bcd_to_binary_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_BLANK      = 4'hA;
   localparam int         DEF_NUM_DIGITS = 8;
   localparam int         DEF_BIN_WIDTH  = 24;

endpackage

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter: one digit per cycle, MSD first,
// multiply-by-ten accumulate with leading-blank handling and saturation.
module bcd_to_binary
   import bcd_to_binary_pkg::*;
#(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int BIN_WIDTH  = DEF_BIN_WIDTH
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    start,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   output logic [BIN_WIDTH-1:0]    binary_out,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow,
   output logic                    err
);

   localparam int ACC_W = 4 * NUM_DIGITS;
   localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CMP_W = ((ACC_W > BIN_WIDTH) ? ACC_W : BIN_WIDTH) + 1;

   state_t             state;
   logic [ACC_W-1:0]   sreg;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               seen_digit;
   logic               err_acc;

   logic [3:0]         top_d;
   logic [3:0]         d_val;
   logic               seen_next;
   logic               err_next;
   logic [ACC_W-1:0]   acc_next;
   logic [CMP_W-1:0]   acc_ext;
   logic [CMP_W-1:0]   max_ext;
   logic               ovf_next;
   logic               last_digit;

   assign top_d      = sreg[ACC_W-1 -: 4];
   assign last_digit = (cnt == CNT_W'(NUM_DIGITS - 1));

   // Illegal digits contribute zero but still shift the accumulator by a decade.
   always_comb begin
      d_val     = 4'd0;
      seen_next = seen_digit;
      err_next  = err_acc;
      if (top_d <= 4'd9) begin
         d_val     = top_d;
         seen_next = 1'b1;
      end else if (top_d != BCD_BLANK || seen_digit) begin
         err_next  = 1'b1;
      end
      acc_next = (acc << 3) + (acc << 1) + ACC_W'(d_val);
      acc_ext  = CMP_W'(acc_next);
      max_ext  = CMP_W'({BIN_WIDTH{1'b1}});
      ovf_next = (acc_ext > max_ext);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state      <= ST_IDLE;
         sreg       <= '0;
         acc        <= '0;
         cnt        <= '0;
         seen_digit <= 1'b0;
         err_acc    <= 1'b0;
         binary_out <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sreg       <= bcd_in;
                  acc        <= '0;
                  cnt        <= '0;
                  seen_digit <= 1'b0;
                  err_acc    <= 1'b0;
                  busy       <= 1'b1;
                  state      <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               sreg       <= sreg << 4;
               acc        <= acc_next;
               cnt        <= cnt + CNT_W'(1);
               seen_digit <= seen_next;
               err_acc    <= err_next;
               if (last_digit) begin
                  binary_out <= ovf_next ? {BIN_WIDTH{1'b1}} : acc_ext[BIN_WIDTH-1:0];
                  overflow   <= ovf_next;
                  err        <= err_next;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboarded bench for bcd_to_binary: directed corner cases plus randomized
// digit strings checked against a decimal-arithmetic reference model.
module tb_bcd_to_binary;

   localparam int ND = 8;
   localparam int BW = 24;

   typedef struct {
      logic [BW-1:0] bin;
      logic          ovf;
      logic          err;
      logic [31:0]   src;
   } exp_t;

   logic            clk_in = 1'b0;
   logic            rst_in;
   logic            start;
   logic [4*ND-1:0] bcd_in;
   logic [BW-1:0]   binary_out;
   logic            busy;
   logic            done;
   logic            overflow;
   logic            err;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];
   logic prev_done = 1'b0;

   bcd_to_binary #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .start(start), .bcd_in(bcd_in),
      .binary_out(binary_out), .busy(busy), .done(done),
      .overflow(overflow), .err(err)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain decimal evaluation of the digit string.
   function automatic exp_t model(input logic [31:0] b);
      exp_t   r;
      longint v    = 0;
      bit     seen = 0;
      bit     e    = 0;
      logic [3:0] d;
      for (int i = ND - 1; i >= 0; i--) begin
         d = b[i*4 +: 4];
         if (d <= 4'd9) begin
            v    = v * 10 + longint'(d);
            seen = 1;
         end else begin
            if (d != 4'hA || seen) e = 1;
            v = v * 10;
         end
      end
      r.ovf = (v > longint'(2**BW - 1));
      r.bin = r.ovf ? {BW{1'b1}} : v[BW-1:0];
      r.err = e;
      r.src = b;
      return r;
   endfunction

   always @(negedge clk_in) begin
      if (!rst_in && done) begin
         exp_t e;
         chk("busy_with_done", busy, 0);
         chk("done_width", prev_done, 0);
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done with no pending conversion, required none");
         end else begin
            e = sb_q.pop_front();
            chk($sformatf("binary_out[%h]", e.src), binary_out, e.bin);
            chk($sformatf("overflow[%h]", e.src), overflow, e.ovf);
            chk($sformatf("err[%h]", e.src), err, e.err);
         end
      end
      prev_done <= done;
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wait_done(input int exp_lat);
      int lat = 0;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (done) begin
            lat = i;
            break;
         end
      end
      chk("latency", lat, exp_lat);
      step();
      chk("done_low_after", done, 0);
   endtask

   task automatic do_conv(input logic [31:0] b);
      bcd_in = b;
      start  = 1'b1;
      sb_q.push_back(model(b));
      step();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      wait_done(ND);
   endtask

   function automatic logic [31:0] rand_bcd();
      logic [31:0] b;
      int nblank;
      if ($urandom_range(0, 7) == 0) return $urandom();
      nblank = $urandom_range(0, ND);
      for (int i = ND - 1; i >= 0; i--) begin
         if (ND - 1 - i < nblank)               b[i*4 +: 4] = 4'hA;
         else if ($urandom_range(0, 9) == 0)    b[i*4 +: 4] = 4'($urandom_range(10, 15));
         else                                    b[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      return b;
   endfunction

   initial begin
      rst_in = 1'b1;
      start  = 1'b0;
      bcd_in = '0;
      step();
      step();
      chk("rst_binary_out", binary_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_flags", {overflow, err}, 0);
      rst_in = 1'b0;
      step();

      do_conv(32'hAAAA_1234);
      do_conv(32'h1677_7215);
      do_conv(32'h1677_7216);
      do_conv(32'h12A4_0000);
      do_conv(32'h0000_00F1);
      do_conv(32'hAAAA_AAAA);
      do_conv(32'h0000_0000);
      do_conv(32'h9999_9999);

      // Second start during the third busy cycle must be ignored.
      bcd_in = 32'h0000_0099;
      start  = 1'b1;
      sb_q.push_back(model(32'h0000_0099));
      step();
      start = 1'b0;
      step();
      step();
      bcd_in = 32'h0000_0055;
      start  = 1'b1;
      step();
      start  = 1'b0;
      bcd_in = '0;
      wait_done(ND - 3);

      // Reset during the fourth busy cycle aborts with no done pulse.
      bcd_in = 32'h0000_0500;
      start  = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      chk("abort_binary_out", binary_out, 0);
      chk("abort_busy_done", {busy, done}, 0);
      chk("abort_flags", {overflow, err}, 0);
      for (int i = 0; i < ND + 2; i++) step();
      do_conv(32'h0000_0007);

      for (int n = 0; n < 40; n++) do_conv(rand_bcd());

      chk("scoreboard_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
